mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single unified `Memory` block between the instruction-fetch path and the data (load/store) path of the multicycle MIPS core. Each requester raises a request with address, and data for stores; the arbiter grants one at a time with round-robin fairness and drives the memory's `R_WBAR`/`ADDR`/`WDATA`. After a fixed access latency it returns read data, or completes a write, with a one-cycle acknowledge. It sits between the control/datapath and `Memory`, replacing the direct IorD address mux.

## Interface

**Parameters**
- `DATA_W`, 32: width of address and data buses.
- `LATENCY`, 1: memory access cycles per transaction; legal values are 1 to 15.

**Ports**
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-high reset.
- `I_REQ` in 1: instruction-fetch request (read only).
- `I_ADDR` in DATA_W: fetch address; held stable while `I_REQ` is high until `I_ACK`.
- `I_ACK` out 1: one-cycle pulse, fetch complete.
- `I_RDATA` out DATA_W: registered fetch data; valid when `I_ACK` is high, held until the next fetch completes.
- `D_REQ` in 1: data request.
- `D_WE` in 1: 1 = store, 0 = load; held with `D_REQ`.
- `D_ADDR` in DATA_W: data address.
- `D_WDATA` in DATA_W: store data.
- `D_ACK` out 1: one-cycle pulse, data access complete.
- `D_RDATA` out DATA_W: registered load data; valid with `D_ACK`, held otherwise. Unchanged by stores.
- `M_R_WBAR` out 1: to `Memory`; 1 = read, 0 = write.
- `M_ADDR` out DATA_W: to `Memory`.
- `M_WDATA` out DATA_W: to `Memory`.
- `M_RDATA` in DATA_W: from `Memory`.
- `BUSY` out 1: high in any state other than IDLE.

## Operation

**States:** IDLE, ACCESS, DONE.

**IDLE**
- If neither request is high at a rising edge, stay in IDLE.
- If exactly one request is high, grant that requester.
- If both are high, grant the port not granted last (round-robin). The last-grant register resets to D, so the first tie goes to I.
- On a grant:
  - Latch address, write enable (forced 0 for I), write data and grant ID.
  - Load the counter with `LATENCY-1`.
  - Go to ACCESS.

**ACCESS**
- Drive `M_ADDR` and `M_WDATA` from the latched registers for every ACCESS cycle.
- For a store, `M_R_WBAR` = 0 only in the first ACCESS cycle; it is 1 in all other cycles and states.
- Decrement the counter each cycle.
- When the counter reaches 0:
  - For a load, capture `M_RDATA` into `I_RDATA` or `D_RDATA` (by grant ID).
  - Update last-grant.
  - Go to DONE.

**DONE**
- Pulse the ACK of the granted port for exactly one cycle; the other ACK stays 0.
- Go to IDLE.
- Requests are not sampled in DONE.

**Requester rules and protocol behaviour**
- A requester keeps REQ and its operands stable until it sees ACK, and drops REQ in the cycle after ACK. A REQ still high in IDLE starts a new transaction.
- Dropping REQ or changing operands after the grant does not affect the transaction: it completes and ACK still pulses.
- I_ACK and D_ACK are never high in the same cycle.

**Reset**
- `RST` asserted at any time, including mid-ACCESS, forces immediately, without waiting for `CLK`:
  - state IDLE, counter 0, last-grant D;
  - `I_ACK` = `D_ACK` = 0, `BUSY` = 0;
  - `I_RDATA` = `D_RDATA` = 0;
  - `M_R_WBAR` = 1, `M_ADDR` = 0, `M_WDATA` = 0.
- An aborted transaction produces no ACK.
- A store aborted during its strobe cycle must not leave `M_R_WBAR` low.

## Timing

- REQ is sampled at edge k in IDLE. ACCESS spans cycles k+1 … k+LATENCY; DONE (ACK high) is cycle k+LATENCY+1.
- Request-to-ACK is LATENCY+1 cycles. With LATENCY=1, ACK comes 2 cycles after the sampling edge.
- A transaction occupies LATENCY+2 cycles including IDLE, so back-to-back throughput is one access per LATENCY+2 cycles.
- Read data is captured at the edge ending the last ACCESS cycle and appears on xRDATA in the DONE cycle.
- `M_*` outputs are registered or state-decoded. No combinational path exists from any REQ to `M_*`.
- `BUSY` is high during ACCESS and DONE.

## Test plan

1. **Reset values.** Assert `RST` with random inputs.
   - All outputs hold their listed reset values.
   - `M_R_WBAR` = 1 without any clock edge.
2. **Single load.** LATENCY=1; memory word 5 preloaded with 9; `I_REQ` with `I_ADDR` = 5.
   - `M_ADDR` = 5 with `M_R_WBAR` = 1 for 1 cycle.
   - `I_ACK` pulses 2 cycles after sampling, with `I_RDATA` = 9.
   - `D_ACK` stays 0.
3. **Store then load.** `D_REQ`, `D_WE` = 1, `D_ADDR` = 10, `D_WDATA` = 27.
   - `M_R_WBAR` = 0 for exactly 1 cycle.
   - `D_ACK` pulses and `D_RDATA` is unchanged.
   - A following load from address 10 returns 27.
4. **Simultaneous requests.** `I_REQ` and `D_REQ` both held high from reset.
   - Grants alternate I, D, I, D.
   - ACK pulses never overlap.
   - Each transaction takes 3 cycles at LATENCY=1.
5. **Longer latency and early drop.** LATENCY=3; the requester drops REQ and changes the address after the grant.
   - ACCESS lasts 3 cycles on the original address.
   - ACK comes 4 cycles after sampling.
6. **Mid-transaction reset.** Pulse `RST` during the first ACCESS cycle of a store.
   - The write strobe ends immediately.
   - No ACK is produced.
   - After release, a new `I_REQ` wins the tie against a simultaneous `D_REQ`.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified Memory between the instruction-fetch
// port (read only) and the data port (load/store). One transaction at a time,
// round-robin on ties, fixed LATENCY access cycles, one-cycle ACK in DONE.
//
// Handshake: a requester raises xREQ with stable operands and keeps them until
// it sees xACK (one-cycle pulse), then drops xREQ the following cycle. Operands
// are latched at the grant edge, so later changes or an early drop of xREQ do
// not disturb the transaction in flight. xRDATA is valid with xACK and held.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [DATA_W-1:0] I_ADDR,
    output logic              I_ACK,
    output logic [DATA_W-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [DATA_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_ACK,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              M_R_WBAR,
    output logic [DATA_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic              BUSY,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic       GNT_I    = 1'b0;
    localparam logic       GNT_D    = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              grant_id;
    logic              lat_we;
    logic              first_cycle;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              grant_valid;
    logic              grant_sel;

    // Next-state and arbitration; requests are only looked at in IDLE.
    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_sel   = GNT_I;
        case (state)
            IDLE: begin
                if (I_REQ || D_REQ) begin
                    grant_valid = 1'b1;
                    if (I_REQ && D_REQ) grant_sel = ~last_grant;
                    else                grant_sel = D_REQ;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transaction without an ACK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, latency counter, read-data capture and round-robin memory.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= 4'd0;
            last_grant  <= GNT_D;
            grant_id    <= GNT_I;
            lat_we      <= 1'b0;
            first_cycle <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else if (grant_valid) begin
            lat_addr    <= grant_sel ? D_ADDR : I_ADDR;
            lat_wdata   <= grant_sel ? D_WDATA : '0;
            lat_we      <= grant_sel & D_WE;
            grant_id    <= grant_sel;
            cnt         <= CNT_INIT;
            first_cycle <= 1'b1;
        end else if (state == ACCESS) begin
            first_cycle <= 1'b0;
            if (cnt == 4'd0) begin
                last_grant <= grant_id;
                if (!lat_we) begin
                    if (grant_id == GNT_D) d_rdata_q <= M_RDATA;
                    else                   i_rdata_q <= M_RDATA;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Memory side is decoded from registers only; the write strobe lasts one
    // ACCESS cycle and drops with the state register on reset.
    always_comb begin
        M_R_WBAR  = ~((state == ACCESS) && lat_we && first_cycle);
        M_ADDR    = lat_addr;
        M_WDATA   = lat_wdata;
        I_ACK     = (state == DONE) && (grant_id == GNT_I);
        D_ACK     = (state == DONE) && (grant_id == GNT_D);
        I_RDATA   = i_rdata_q;
        D_RDATA   = d_rdata_q;
        BUSY      = (state != IDLE);
        dbg_state = state;
    end

endmodule
